// File: rtl/nios_dbg_jtag_driver.sv
// nios_dbg_jtag_driver: drives the virtual-JTAG (vji_*) signal set of a Nios II debug slave from the system clock.
// Optional feature: define DBG_JTAG_IR_CACHE_EN to skip the UIR state when the IR equals the previous command's IR.
module nios_dbg_jtag_driver #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int DIVW = $clog2(2 * TCK_DIV) + 1;
    localparam int CNTW = $clog2(DR_WIDTH + 1);
    localparam logic [DIVW-1:0] DIV_PRE  = DIVW'(TCK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_HI   = DIVW'(TCK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * TCK_DIV - 1);
    localparam logic [CNTW-1:0] CNT_END  = CNTW'(DR_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP} state_t;

    state_t              r_state;
    logic [DIVW-1:0]     r_div;
    logic [CNTW-1:0]     r_cnt;
    logic [DR_WIDTH-1:0] r_shreg;
    logic                w_last;
    logic                w_rise;
    logic                w_hit;
    logic [DR_WIDTH-1:0] w_shreg;
    logic [CNTW-1:0]     w_cnt;
    state_t              w_nxt;

`ifdef DBG_JTAG_IR_CACHE_EN
    logic [IR_WIDTH-1:0] r_ir_q;
    assign w_hit = (cmd_ir == r_ir_q);
`else
    assign w_hit = 1'b0;
`endif

    // Period bookkeeping, the shift at each tck rising edge, and the state following the current period.
    always_comb begin
        w_last  = (r_div == DIV_LAST);
        w_rise  = (r_state == S_SDR) && (r_div == DIV_HI);
        w_shreg = w_rise ? {vji_tdo, r_shreg[DR_WIDTH-1:1]} : r_shreg;
        w_cnt   = w_rise ? r_cnt + CNTW'(1) : r_cnt;
        w_nxt   = (r_state == S_UIR) ? S_CDR :
                  (r_state == S_CDR) ? S_SDR :
                  (r_state == S_SDR) ? ((w_cnt == CNT_END) ? S_UDR : S_SDR) :
                  (r_state == S_UDR) ? S_RTI :
                  (r_state == S_RTI) ? S_RESP : S_IDLE;
    end

    // Command FSM; every output is registered and set up for the state it enters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_cnt      <= '0;
            r_shreg    <= '0;
`ifdef DBG_JTAG_IR_CACHE_EN
            r_ir_q     <= '0;
`endif
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state   <= w_hit ? S_CDR : S_UIR;
                        r_div     <= '0;
                        r_cnt     <= '0;
                        r_shreg   <= cmd_data;
`ifdef DBG_JTAG_IR_CACHE_EN
                        r_ir_q    <= cmd_ir;
`endif
                        cmd_ready <= 1'b0;
                        vji_uir   <= !w_hit;
                        vji_cdr   <= w_hit;
                        if (!w_hit)
                            vji_ir_in <= cmd_ir;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    r_div   <= w_last ? '0 : r_div + DIVW'(1);
                    vji_tck <= !w_last && (r_div >= DIV_PRE);
                    r_shreg <= w_shreg;
                    r_cnt   <= w_cnt;
                    if (r_state == S_UDR)
                        rsp_ir_out <= vji_ir_out;
                    if (w_last) begin
                        r_state <= w_nxt;
                        vji_uir <= 1'b0;
                        vji_cdr <= (w_nxt == S_CDR);
                        vji_sdr <= (w_nxt == S_SDR);
                        vji_udr <= (w_nxt == S_UDR);
                        vji_rti <= (w_nxt == S_RTI);
                        vji_tdi <= (w_nxt == S_SDR) ? w_shreg[0] : 1'b0;
                        if (w_nxt == S_RESP) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= w_shreg;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nios_dbg_jtag_driver.sv
// tb_nios_dbg_jtag_driver: directed and randomized commands against a behavioural debug-slave and timing model.
module tb_nios_dbg_jtag_driver;
    localparam int DW  = 38;
    localparam int IW  = 2;
    localparam int TD  = 4;
    localparam int PER = 2 * TD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IW-1:0] cmd_ir = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [IW-1:0] rsp_ir_out;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [IW-1:0] vji_ir_in;
    logic [IW-1:0] vji_ir_out;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    // Slave model: loads its word during capture, shifts tdi in at each tck rise, drives its LSB on tdo.
    logic          sl_loop = 1'b1;
    logic [DW-1:0] sl_word = '0;
    logic [DW-1:0] sl_sr = '0;
    logic [IW-1:0] sl_ir_out = '0;
    logic          sl_tck_q = 1'b0;

    int npass = 0;
    int ntot = 0;
    int n_acc = 0;
    logic [IW-1:0] m_ir_q = '0;
    logic [IW-1:0] m_ir_in = '0;

    always #5 clk = ~clk;

    assign vji_tdo    = sl_loop ? vji_tdi : sl_sr[0];
    assign vji_ir_out = sl_ir_out;

    nios_dbg_jtag_driver #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
        .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    // Slave shift register, clocked off tck rising edges seen at clk.
    always @(posedge clk) begin
        sl_tck_q <= vji_tck;
        if (vji_cdr)
            sl_sr <= sl_word;
        else if (vji_sdr && vji_tck && !sl_tck_q)
            sl_sr <= {vji_tdi, sl_sr[DW-1:1]};
    end

    // Accepted-command counter.
    always @(posedge clk)
        if (reset_n && cmd_valid && cmd_ready)
            n_acc <= n_acc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit ir_hit(input logic [IW-1:0] ir);
`ifdef DBG_JTAG_IR_CACHE_EN
        return ir == m_ir_q;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'd0);
        chk({tag, "_tck"}, 64'(vji_tck), 64'd0);
        chk({tag, "_tdi"}, 64'(vji_tdi), 64'd0);
        chk({tag, "_ir_in"}, 64'(vji_ir_in), 64'd0);
        chk({tag, "_ind"}, 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
    endtask

    task automatic do_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] data, input logic [DW-1:0] word,
                          input bit loop, input logic [IW-1:0] irout, input bit hold);
        logic [DW-1:0] exp_d;
        logic [24:0]   seq, exp_seq;
        logic [4:0]    ind, prev_ind;
        logic [DW-1:0] got_d;
        logic [IW-1:0] got_ir;
        logic          prev_tck;
        bit h;
        int exp_lat, lat, n_rise, n_sdr_rise, bad, n_tr, acc0;
        exp_d = loop ? data : word;
        h = ir_hit(ir);
        exp_lat = 1 + (DW + (h ? 3 : 4)) * PER;
        exp_seq = h ? 25'b00000_01000_00100_00010_00001 : 25'b10000_01000_00100_00010_00001;
        lat = 0; n_rise = 0; n_sdr_rise = 0; bad = 0; n_tr = 0;
        seq = '0; prev_ind = '0; prev_tck = 1'b0; got_d = '0; got_ir = '0;
        @(negedge clk);
        chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
        sl_loop = loop; sl_word = word; sl_ir_out = irout;
        cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
        acc0 = n_acc;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        for (int n = 1; n <= 2000 && lat == 0; n++) begin
            ind = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
            if (hold) begin
                cmd_data = DW'({$urandom(), $urandom()});
                cmd_ir = IW'($urandom_range(3));
            end
            if (cmd_ready) bad++;
            if (rsp_valid) begin
                lat = n; got_d = rsp_data; got_ir = rsp_ir_out;
                if (ind != 0 || vji_tck) bad++;
            end else if ($countones(ind) != 1) bad++;
            if (!vji_sdr && vji_tdi) bad++;
            if (vji_uir && vji_ir_in !== ir) bad++;
            if (ind != prev_ind && ind != 0) begin
                seq = {seq[19:0], ind};
                n_tr++;
            end
            if (vji_tck && !prev_tck) begin
                n_rise++;
                if (vji_sdr) n_sdr_rise++;
            end
            prev_ind = ind; prev_tck = vji_tck;
            if (lat == 0) @(negedge clk);
        end
        @(negedge clk);
        chk("ready_after_resp", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_data", 64'(got_d), 64'(exp_d));
        chk("rsp_ir_out", 64'(got_ir), 64'(irout));
        chk("per_cycle_rules", 64'(bad), 64'd0);
        chk("sdr_tck_rises", 64'(n_sdr_rise), 64'(DW));
        chk("tck_rises", 64'(n_rise), 64'(DW + (h ? 3 : 4)));
        chk("state_order", 64'(seq), 64'(exp_seq));
        chk("state_count", 64'(n_tr), 64'(h ? 4 : 5));
        chk("accepts", 64'(n_acc - acc0), 64'd1);
        if (!h) m_ir_in = ir;
        m_ir_q = ir;
        chk("ir_in_held", 64'(vji_ir_in), 64'(m_ir_in));
        if (!loop) chk("slave_got_dr", 64'(sl_sr), 64'(data));
    endtask

    initial begin
        int quiet;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        do_cmd(2'b01, 38'h0_0000_0001, '0, 1'b1, 2'b00, 1'b0);
        do_cmd(2'b00, '0, 38'h2A_5A5A_5A5A, 1'b0, 2'b10, 1'b0);
        do_cmd(2'b11, DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}), 1'b0, 2'b01, 1'b0);
        do_cmd(2'b11, DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}), 1'b0, 2'b10, 1'b0);
        do_cmd(IW'($urandom_range(3)), DW'({$urandom(), $urandom()}), '0, 1'b1, IW'($urandom_range(3)), 1'b1);
        // Abort a command mid-flight while tck is high.
        @(negedge clk);
        cmd_ir = 2'b10; cmd_data = DW'({$urandom(), $urandom()}); cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("tck_high_before_abort", 64'(vji_tck), 64'd1);
        #1 reset_n = 1'b0;
        #1 check_reset_vals("abort");
        m_ir_q = '0; m_ir_in = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        quiet = 0;
        repeat (400) begin
            @(negedge clk);
            if (rsp_valid) quiet++;
        end
        chk("no_rsp_after_abort", 64'(quiet), 64'd0);
        do_cmd(2'b10, DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}), 1'b0, 2'b11, 1'b0);
        for (int k = 0; k < 4; k++)
            do_cmd(IW'($urandom_range(3)), DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}),
                   1'($urandom_range(1)), IW'($urandom_range(3)), 1'b0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/nios_dbg_jtag_driver.md
# nios_dbg_jtag_driver

On-chip initiator for the Nios II debug slave's virtual-JTAG port. It accepts one debug command at a time (2-bit IR plus a 38-bit DR word) and drives the vji_* signal set as the Altera virtual-JTAG hub would: IR update, DR capture, shift, update and run-test-idle. The DR bits shifted out by the slave are returned as the response. It allows a system-clock master to exercise the debug slave without an external JTAG cable, for example in self-test or simulation.

## Interface

Parameters:
- DR_WIDTH, 38, DR shift length (matches the slave's sr/jdo width).
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 4, clk cycles per tck half-period; legal range is 1 or more.

Ports:
- clk  in  1  system clock; the only clock. vji_tck is generated from it.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_data  in  DR_WIDTH  DR word to shift in, LSB first.
- rsp_valid  out  1  one-cycle pulse; rsp_data and rsp_ir_out are valid in that cycle.
- rsp_data  out  DR_WIDTH  DR bits captured from vji_tdo.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out, sampled in the UDR state.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  current virtual IR.
- vji_ir_out  in  IR_WIDTH  slave status IR.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual TAP state indicators.

## Operation

- FSM states: IDLE → UIR → CDR → SDR → UDR → RTI → RESP → IDLE.
- On command accept, cmd_ir and cmd_data are latched into ir_q and shreg, and the bit counter is cleared.
- Each non-IDLE state except RESP lasts whole tck periods. A period is 2*TCK_DIV clk cycles: vji_tck low for the first TCK_DIV cycles, high for the second TCK_DIV cycles.
- State indicators:
  - vji_uir is 1 for the entire UIR state; vji_cdr, vji_sdr, vji_udr and vji_rti likewise for CDR, SDR, UDR and RTI.
  - Exactly one indicator is high in any non-IDLE, non-RESP state; all are 0 in IDLE and RESP.
- vji_ir_in takes the value ir_q at entry to UIR and holds it until the next UIR. It is not cleared in IDLE.
- SDR lasts DR_WIDTH periods.
  - vji_tdi = shreg[0] is updated at the start of each period, i.e. at the tck falling edge.
  - On the clk cycle of each tck rising edge, vji_tdo is sampled: shreg shifts right, with tdo entering at the MSB, and the counter increments.
  - After DR_WIDTH shifts, shreg holds the slave's word in its original bit order.
- In UDR, rsp_ir_out is latched from vji_ir_out.
- RESP lasts one clk cycle: rsp_valid = 1 and rsp_data = shreg. There is no backpressure on the response.
- vji_tck stays low in IDLE and RESP. vji_tdi is 0 outside SDR.
- A cmd_valid that arrives while the block is busy is ignored; cmd_ready = 0 from the accept cycle +1 through RESP.

## Timing

- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ir_out=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, all state indicators 0. The FSM is in IDLE and ir_q=0.
- An accept in cycle 0 makes UIR start in cycle 1.
- rsp_valid occurs in cycle 1 + (DR_WIDTH+4)*2*TCK_DIV. With default parameters this is cycle 337.
- cmd_ready returns to 1 in the cycle after rsp_valid. Back-to-back commands are accepted in that cycle.
- An assertion of reset_n low mid-command aborts the command immediately, with no response. vji_tck drops asynchronously and all outputs take their reset values.
- TCK_DIV=1 gives vji_tck = clk/2 with no idle cycles between periods.

## Configuration

- DBG_JTAG_IR_CACHE_EN:
  - Defined: the UIR state is skipped when cmd_ir equals ir_q from the previous command (ir_q is reset to 0). A hit has latency 1 + (DR_WIDTH+3)*2*TCK_DIV, which is 329 with defaults.
  - Undefined: UIR executes for every command.

## Test plan

- Reset, then cmd_ir=2'b01, cmd_data=38'h0_0000_0001 with vji_tdo looped to vji_tdi:
  - Expect rsp_valid in cycle 337 with rsp_data=38'h0_0000_0001.
  - Expect vji_ir_in=2'b01 during UIR.
- Slave model returns 38'h2A_5A5A_5A5A while cmd_data=0. Expect rsp_data=38'h2A_5A5A_5A5A and 38 tck rising edges with vji_sdr=1.
- vji_ir_out held at 2'b10. Expect rsp_ir_out=2'b10. Also check that exactly one state indicator is high per tck period, in the order UIR, CDR, SDR, UDR, RTI.
- Pull reset_n low at cycle 100 of a command. Expect all outputs at reset values, no rsp_valid, and a subsequent command to complete normally.
- Two consecutive commands with ir=2'b11:
  - With DBG_JTAG_IR_CACHE_EN defined, the second response arrives 329 cycles after its accept and vji_uir never pulses.
  - Without the macro, the second response arrives after 337 cycles.
- Hold cmd_valid high while busy with changing cmd_data. Expect only the first command to be accepted, and cmd_ready=0 until RESP+1.
